cp0: RTL and testbench

- Coprocessor-0 block for the MIPS32 core.
- Holds the SR, Cause, EPC and PRId registers, detects enabled hardware interrupts and synchronous exceptions, and captures the return PC.
- Sits directly upstream of the next-PC logic.
  - int_req selects the handler-entry path (fixed vector 0x0000_4180).
  - epc_out is the eret target address.
  - mfc0 read data goes to the writeback mux.

---
 rtl/cp0_if.sv | 25 ++
 rtl/cp0.sv | 101 ++++++++++
 tb/tb_cp0.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/cp0_if.sv
// Core <-> CP0 bus: commit-stage strobes, mfc0/mtc0 ports, interrupt lines and the nPC-facing outputs.
interface cp0_if;
  logic [31:0] pc;
  logic [4:0]  rd_addr;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_en;
  logic        exc_req;
  logic [4:0]  exc_code;
  logic        eret;
  logic [5:0]  hw_int;
  logic        int_req;
  logic [31:0] epc_out;
  logic [31:0] rd_data;

  modport master (
    output pc, rd_addr, wr_addr, wr_data, wr_en, exc_req, exc_code, eret, hw_int,
    input  int_req, epc_out, rd_data
  );

  modport slave (
    input  pc, rd_addr, wr_addr, wr_data, wr_en, exc_req, exc_code, eret, hw_int,
    output int_req, epc_out, rd_data
  );
endinterface

// File: rtl/cp0.sv
// MIPS32 coprocessor 0: SR/Cause/EPC/PRId, interrupt and exception entry, eret and mtc0/mfc0.
module cp0 #(
  parameter logic [31:0] PRID = 32'h4C4A_5900
) (
  input  logic clk,
  input  logic reset,
  cp0_if.slave bus
);

  localparam int unsigned IM_W   = 6;
  localparam int unsigned CODE_W = 5;
  localparam int unsigned EPC_W  = 30;

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  logic [IM_W-1:0]   sr_im_q,    sr_im_d;
  logic              sr_exl_q,   sr_exl_d;
  logic              sr_ie_q,    sr_ie_d;
  logic [IM_W-1:0]   cause_ip_q;
  logic [CODE_W-1:0] exc_code_q, exc_code_d;
  logic [EPC_W-1:0]  epc_q,      epc_d;

  logic irq;
  logic take;
  logic wr_sr;
  logic wr_epc;
  logic unused_pc;

  // Entry decision is combinational: nPC consumes int_req in the same cycle.
  always_comb begin
    irq  = (|(bus.hw_int & sr_im_q)) & sr_ie_q & ~sr_exl_q;
    take = irq | (bus.exc_req & ~sr_exl_q);
  end

  assign wr_sr     = bus.wr_en && (bus.wr_addr == ADDR_SR);
  assign wr_epc    = bus.wr_en && (bus.wr_addr == ADDR_EPC);
  assign unused_pc = ^bus.pc[1:0];

  // Next-state: mtc0 first, then eret clears EXL, then entry overrides both.
  always_comb begin
    sr_im_d    = sr_im_q;
    sr_ie_d    = sr_ie_q;
    sr_exl_d   = sr_exl_q;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;

    if (wr_sr) begin
      sr_im_d  = bus.wr_data[15:10];
      sr_exl_d = bus.wr_data[1];
      sr_ie_d  = bus.wr_data[0];
    end
    if (wr_epc) begin
      epc_d = bus.wr_data[31:2];
    end
    if (bus.eret) begin
      sr_exl_d = 1'b0;
    end
    if (take) begin
      sr_exl_d   = 1'b1;
      epc_d      = bus.pc[31:2];
      exc_code_d = irq ? CODE_W'(0) : bus.exc_code;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_im_q    <= '0;
      sr_exl_q   <= 1'b0;
      sr_ie_q    <= 1'b0;
      cause_ip_q <= '0;
      exc_code_q <= '0;
      epc_q      <= '0;
    end else begin
      sr_im_q    <= sr_im_d;
      sr_exl_q   <= sr_exl_d;
      sr_ie_q    <= sr_ie_d;
      cause_ip_q <= bus.hw_int;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
    end
  end

  assign bus.int_req = take;
  assign bus.epc_out = {epc_q, 2'b00};

  // mfc0 reads current state; a same-cycle mtc0 is not bypassed.
  always_comb begin
    bus.rd_data = 32'h0;
    case (bus.rd_addr)
      ADDR_SR:    bus.rd_data = {16'h0, sr_im_q, 8'h0, sr_exl_q, sr_ie_q};
      ADDR_CAUSE: bus.rd_data = {16'h0, cause_ip_q, 3'b000, exc_code_q, 2'b00};
      ADDR_EPC:   bus.rd_data = {epc_q, 2'b00};
      ADDR_PRID:  bus.rd_data = PRID;
      default:    bus.rd_data = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_cp0.sv
// Directed and randomized checks of cp0 against a word-level model of the CP0 register rules.
module tb_cp0;

  localparam logic [31:0] PRID = 32'h4C4A_5900;

  logic clk;
  logic reset;
  cp0_if bus ();

  cp0 #(.PRID(PRID)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  // Model state as whole 32-bit register images.
  logic [31:0] m_sr, m_cause, m_epc;
  logic [31:0] n_sr, n_cause, n_epc;
  logic        m_valid;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apply(input logic rst, input logic wen, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [4:0] ra, input logic exc,
                       input logic [4:0] code, input logic er, input logic [5:0] hw,
                       input logic [31:0] p);
    logic        irq, take;
    logic [31:0] exp_rd;
    logic [4:0]  cur_code;
    reset        = rst;
    bus.wr_en    = wen;
    bus.wr_addr  = wa;
    bus.wr_data  = wd;
    bus.rd_addr  = ra;
    bus.exc_req  = exc;
    bus.exc_code = code;
    bus.eret     = er;
    bus.hw_int   = hw;
    bus.pc       = p;
    #1;
    irq  = ((hw & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
    take = irq || (exc && !m_sr[1]);
    case (ra)
      5'd12:   exp_rd = m_sr;
      5'd13:   exp_rd = m_cause;
      5'd14:   exp_rd = m_epc;
      5'd15:   exp_rd = PRID;
      default: exp_rd = 32'h0;
    endcase
    if (m_valid) begin
      check("int_req", 32'(bus.int_req), 32'(take));
      check("epc_out", bus.epc_out, m_epc);
      check("rd_data", bus.rd_data, exp_rd);
    end
    if (rst) begin
      n_sr = 0; n_cause = 0; n_epc = 0;
    end else begin
      n_sr = m_sr;
      if (wen && wa == 5'd12) n_sr = wd & 32'h0000_FC03;
      if (er) n_sr = n_sr & ~32'h2;
      if (take) n_sr = n_sr | 32'h2;
      cur_code = m_cause[6:2];
      if (take) cur_code = irq ? 5'd0 : code;
      n_cause = (32'(hw) << 10) | (32'(cur_code) << 2);
      n_epc = m_epc;
      if (wen && wa == 5'd14) n_epc = wd & ~32'h3;
      if (take) n_epc = p & ~32'h3;
    end
  endtask

  task automatic tick(input logic rst);
    @(posedge clk);
    m_sr = n_sr; m_cause = n_cause; m_epc = n_epc;
    if (rst) m_valid = 1'b1;
    #1;
  endtask

  initial begin
    n_vec = 0; n_err = 0; m_valid = 1'b0;
    m_sr = 0; m_cause = 0; m_epc = 0;

    // Reset for two cycles, then read every register.
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick(1);
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick(1);
    apply(0, 0, 0, 0, 12, 0, 0, 0, 0, 0);
    check("rst_sr", bus.rd_data, 32'h0);
    check("rst_int_req", 32'(bus.int_req), 32'h0);
    apply(0, 0, 0, 0, 13, 0, 0, 0, 0, 0); check("rst_cause", bus.rd_data, 32'h0);
    apply(0, 0, 0, 0, 14, 0, 0, 0, 0, 0); check("rst_epc", bus.rd_data, 32'h0);
    apply(0, 0, 0, 0, 15, 0, 0, 0, 0, 0); check("prid", bus.rd_data, PRID);
    tick(0);

    // Interrupt entry.
    apply(0, 1, 12, 32'h0000_FC01, 0, 0, 0, 0, 6'b000000, 32'h0); tick(0);
    apply(0, 0, 0, 0, 12, 0, 0, 0, 6'b000100, 32'h0000_3010);
    check("irq_take", 32'(bus.int_req), 32'h1);
    tick(0);
    apply(0, 0, 0, 0, 14, 0, 0, 0, 6'b000100, 32'h0);
    check("irq_epc", bus.rd_data, 32'h0000_3010);
    check("irq_exl_mask", 32'(bus.int_req), 32'h0);
    apply(0, 0, 0, 0, 12, 0, 0, 0, 6'b000100, 32'h0); check("irq_sr", bus.rd_data, 32'h0000_FC03);
    apply(0, 0, 0, 0, 13, 0, 0, 0, 6'b000100, 32'h0); check("irq_cause", bus.rd_data, 32'h0000_1000);
    tick(0);

    // eret returns to EPC and reopens the pending interrupt.
    apply(0, 1, 14, 32'h0000_3404, 0, 0, 0, 0, 6'b000100, 32'h0); tick(0);
    apply(0, 0, 0, 0, 0, 0, 0, 1, 6'b000100, 32'h0);
    check("eret_epc", bus.epc_out, 32'h0000_3404);
    check("eret_no_req", 32'(bus.int_req), 32'h0);
    tick(0);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 6'b000100, 32'h0000_3500);
    check("eret_pending", 32'(bus.int_req), 32'h1);
    tick(0);

    // Masking by IM and by IE.
    apply(0, 1, 12, 32'h0000_0401, 0, 0, 0, 0, 6'b000010, 32'h0); tick(0);
    apply(0, 0, 0, 0, 13, 0, 0, 0, 6'b000010, 32'h0);
    check("mask_im", 32'(bus.int_req), 32'h0);
    check("mask_cause", bus.rd_data, 32'h0000_0800);
    tick(0);
    apply(0, 1, 12, 32'h0000_FC00, 0, 0, 0, 0, 6'b000010, 32'h0); tick(0);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 6'b111111, 32'h0);
    check("mask_ie", 32'(bus.int_req), 32'h0);
    tick(0);

    // Interrupt beats a simultaneous exception; then exception alone.
    apply(0, 1, 12, 32'h0000_FC01, 0, 0, 0, 0, 6'b000000, 32'h0); tick(0);
    apply(0, 0, 0, 0, 0, 1, 5'd10, 0, 6'b000001, 32'h0000_3100); tick(0);
    apply(0, 0, 0, 0, 13, 0, 0, 0, 6'b000000, 32'h0); check("prio_cause", bus.rd_data, 32'h0000_0400);
    apply(0, 0, 0, 0, 0, 0, 0, 1, 6'b000000, 32'h0); tick(0);
    apply(0, 0, 0, 0, 0, 1, 5'd10, 0, 6'b000000, 32'h0000_3204);
    check("exc_take", 32'(bus.int_req), 32'h1);
    tick(0);
    apply(0, 0, 0, 0, 13, 0, 0, 0, 6'b000000, 32'h0); check("exc_cause", bus.rd_data, 32'h0000_0028);
    apply(0, 0, 0, 0, 14, 1, 5'd7, 0, 6'b000000, 32'h0000_3300);
    check("exc_masked", 32'(bus.int_req), 32'h0);
    check("exc_epc", bus.rd_data, 32'h0000_3204);
    tick(0);
    apply(0, 0, 0, 0, 14, 0, 0, 0, 6'b000000, 32'h0); check("exc_masked_epc", bus.rd_data, 32'h0000_3204);

    // mtc0 EPC collisions.
    apply(0, 0, 0, 0, 0, 0, 0, 1, 6'b000000, 32'h0); tick(0);
    apply(0, 1, 14, 32'h0000_5557, 0, 1, 5'd4, 0, 6'b000000, 32'h0000_3020); tick(0);
    apply(0, 0, 0, 0, 14, 0, 0, 0, 6'b000000, 32'h0); check("coll_entry", bus.rd_data, 32'h0000_3020);
    apply(0, 0, 0, 0, 0, 0, 0, 1, 6'b000000, 32'h0); tick(0);
    apply(0, 1, 14, 32'h0000_5557, 14, 0, 0, 0, 6'b000000, 32'h0);
    check("coll_old", bus.rd_data, 32'h0000_3020);
    tick(0);
    apply(0, 0, 0, 0, 14, 0, 0, 0, 6'b000000, 32'h0); check("coll_new", bus.rd_data, 32'h0000_5554);
    tick(0);

    // Randomized traffic checked against the model every cycle.
    for (int i = 0; i < 600; i++) begin
      logic        r_rst, r_wen, r_exc, r_er;
      logic [4:0]  r_wa, r_ra;
      logic [5:0]  r_hw;
      r_rst = ($urandom_range(0, 99) < 2);
      r_wen = ($urandom_range(0, 99) < 30);
      r_wa  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(12, 15));
      r_ra  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(12, 15));
      r_exc = ($urandom_range(0, 99) < 15);
      r_er  = ($urandom_range(0, 99) < 25);
      r_hw  = ($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom);
      apply(r_rst, r_wen, r_wa, $urandom, r_ra, r_exc, 5'($urandom), r_er, r_hw, $urandom);
      tick(r_rst);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
